// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch producer feeding the IF/ID pipeline register. Holds the
// fetch PC and issues reads to a synchronous instruction memory with a
// 1-cycle read latency. Each returning word is queued with its PC+4 in a
// small circular buffer. The buffer head is presented to decode under a
// valid/ready handshake. A redirect squashes all queued and in-flight
// wrong-path work and restarts fetch at the target address.
//
// Parameters
//   RESET_PC   first fetch address after reset (bits [1:0] must be 0)
//   DEPTH      fetch buffer entries (power of two, >= 2)
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   im_addr         out  instruction memory byte address (word aligned)
//   im_en           out  read request; data arrives on im_rdata next cycle
//   im_rdata        in   instruction word for last cycle's request
//   redirect_valid  in   1-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     in   redirect target (bits [1:0] ignored)
//   id_ready        in   decode accepts the presented entry this cycle
//   if_valid        out  if_pc_add / if_inst hold a valid entry
//   if_pc_add       out  PC+4 of the presented instruction
//   if_inst         out  presented instruction word
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] im_addr,
  output logic        im_en,
  input  logic [31:0] im_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc_add,
  output logic [31:0] if_inst
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic [31:0]   buf_pc_add [DEPTH];
  logic [31:0]   buf_inst   [DEPTH];

  logic          pop;
  logic          push;
  logic [CW:0]   occ;

  // Low address bits of the target are forced to zero, never read.
  logic          unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc[1:0];

  // Presentation: head of the buffer, zeroed when nothing is queued.
  assign if_valid  = (count_q != '0);
  assign if_pc_add = if_valid ? buf_pc_add[rd_ptr_q] : 32'd0;
  assign if_inst   = if_valid ? buf_inst[rd_ptr_q]   : 32'd0;

  // A redirect flushes the buffer, so a same-cycle handshake is dropped
  // and the returning wrong-path word is never written.
  assign pop  = if_valid & id_ready & ~redirect_valid;
  assign push = inflight_q & ~redirect_valid;

  // Credit check: slots already taken plus the word in flight, minus the
  // entry leaving this cycle, must leave room for one more read. This is
  // what guarantees a returning word always finds a free slot.
  assign occ = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

  // Gating with reset keeps the memory quiet while the block is held.
  assign im_en   = ~reset & ~redirect_valid & (occ < DEPTH_C);
  assign im_addr = pc_q;

  // Stage boundary: fetch control (PC, in-flight flag, buffer pointers).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= im_en;
      if (im_en) begin
        pc_q <= pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Stage boundary: memory return captured into the buffer.
  always_ff @(posedge clock) begin
    if (im_en) begin
      inflight_pc_q <= pc_q;
    end
    if (push) begin
      buf_pc_add[wr_ptr_q] <= inflight_pc_q + 32'd4;
      buf_inst[wr_ptr_q]   <= im_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// ----------------------------------------------------------------------------
// Bench for if_fetch_unit. Two instances share clock and reset: u_dut starts
// at address 0 and receives directed stall/redirect/reset stimulus; u_wrap
// starts at FFFF_FFF8 to exercise PC wrap-around. Instruction memories are
// modelled as word(addr) = 32'h1000_0000 + addr/4 with 1-cycle read latency.
// A stream model tracks the next address decode must see and checks u_dut's
// presented entry every cycle; directed literal checks pin the latencies.
// ============================================================================
module tb_if_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] im_addr, im_rdata;
  logic        im_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc_add, if_inst;

  logic [31:0] w_im_addr, w_im_rdata;
  logic        w_im_en;
  logic        w_if_valid;
  logic [31:0] w_if_pc_add, w_if_inst;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] exp_pc;
  logic [31:0] held;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clock(clock), .reset(reset),
    .im_addr(im_addr), .im_en(im_en), .im_rdata(im_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_pc_add(if_pc_add), .if_inst(if_inst)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clock(clock), .reset(reset),
    .im_addr(w_im_addr), .im_en(w_im_en), .im_rdata(w_im_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_ready(1'b1),
    .if_valid(w_if_valid), .if_pc_add(w_if_pc_add), .if_inst(w_if_inst)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (im_en)   im_rdata   <= memf(im_addr);
    if (w_im_en) w_im_rdata <= memf(w_im_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Stream model: decode must see consecutive words starting at exp_pc,
  // restarting at the reset PC or the aligned redirect target.
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_im_en", {31'd0, im_en}, 32'd0);
      chk("rst_im_addr", im_addr, 32'h0);
      chk("rst_pc_add", if_pc_add, 32'h0);
      chk("rst_inst", if_inst, 32'h0);
      exp_pc = 32'h0;
    end else begin
      if (if_valid) begin
        chk("model_pc_add", if_pc_add, exp_pc + 32'd4);
        chk("model_inst", if_inst, memf(exp_pc));
      end else begin
        chk("idle_pc_add", if_pc_add, 32'h0);
        chk("idle_inst", if_inst, 32'h0);
      end
      if (redirect_valid) begin
        chk("redir_im_en", {31'd0, im_en}, 32'd0);
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (if_valid && id_ready) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Cycles 0..2 after reset release: issue at 0, first entry at 2.
  task automatic check_startup(input string tag);
    @(negedge clock);
    chk({tag, "_c0_im_en"}, {31'd0, im_en}, 32'd1);
    chk({tag, "_c0_im_addr"}, im_addr, 32'h0);
    chk({tag, "_c0_valid"}, {31'd0, if_valid}, 32'd0);
    next_cycle();
    @(negedge clock);
    chk({tag, "_c1_valid"}, {31'd0, if_valid}, 32'd0);
    next_cycle();
    @(negedge clock);
    chk({tag, "_c2_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_c2_pc_add"}, if_pc_add, 32'h4);
    chk({tag, "_c2_inst"}, if_inst, 32'h1000_0000);
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Test 1 and wrap-around instance share the start-up timeline.
    @(negedge clock);
    chk("t1_c0_im_en", {31'd0, im_en}, 32'd1);
    chk("t1_c0_im_addr", im_addr, 32'h0);
    chk("t5_c0_im_addr", w_im_addr, 32'hFFFF_FFF8);
    chk("t1_c0_valid", {31'd0, if_valid}, 32'd0);
    next_cycle();
    @(negedge clock);
    chk("t1_c1_valid", {31'd0, if_valid}, 32'd0);
    next_cycle();
    @(negedge clock);
    chk("t1_c2_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_c2_pc_add", if_pc_add, 32'h4);
    chk("t1_c2_inst", if_inst, 32'h1000_0000);
    chk("t5_c2_pc_add", w_if_pc_add, 32'hFFFF_FFFC);
    chk("t5_c2_inst", w_if_inst, 32'h4FFF_FFFE);
    next_cycle();
    @(negedge clock);
    chk("t1_c3_pc_add", if_pc_add, 32'h8);
    chk("t1_c3_inst", if_inst, 32'h1000_0001);
    chk("t5_c3_pc_add", w_if_pc_add, 32'h0000_0000);
    chk("t5_c3_inst", w_if_inst, 32'h4FFF_FFFF);
    next_cycle();
    @(negedge clock);
    chk("t1_c4_pc_add", if_pc_add, 32'hC);
    chk("t1_c4_inst", if_inst, 32'h1000_0002);
    chk("t5_c4_pc_add", w_if_pc_add, 32'h0000_0004);
    chk("t5_c4_inst", w_if_inst, 32'h1000_0000);
    repeat (3) next_cycle();

    // Test 2: stall for 5 cycles, head frozen, fetch throttled.
    id_ready = 1'b0;
    @(negedge clock);
    held = if_pc_add;
    chk("t2_held_valid", {31'd0, if_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      chk("t2_stall_pc_add", if_pc_add, held);
      chk("t2_stall_im_en", {31'd0, im_en}, 32'd0);
      next_cycle();
    end
    id_ready = 1'b1;
    @(negedge clock);
    chk("t2_resume_pc_add", if_pc_add, held);
    chk("t2_resume_im_en", {31'd0, im_en}, 32'd1);
    next_cycle();
    @(negedge clock);
    chk("t2_next1_pc_add", if_pc_add, held + 32'd4);
    next_cycle();
    @(negedge clock);
    chk("t2_next2_pc_add", if_pc_add, held + 32'd8);
    next_cycle();

    // Test 3: redirect with a word in flight and the buffer filling.
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    @(negedge clock);
    chk("t3_r_im_en", {31'd0, im_en}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    @(negedge clock);
    chk("t3_r1_valid", {31'd0, if_valid}, 32'd0);
    chk("t3_r1_im_en", {31'd0, im_en}, 32'd1);
    chk("t3_r1_im_addr", im_addr, 32'h40);
    next_cycle();
    @(negedge clock);
    chk("t3_r2_valid", {31'd0, if_valid}, 32'd0);
    next_cycle();
    @(negedge clock);
    chk("t3_r3_valid", {31'd0, if_valid}, 32'd1);
    chk("t3_r3_pc_add", if_pc_add, 32'h44);
    chk("t3_r3_inst", if_inst, 32'h1000_0010);
    repeat (3) next_cycle();

    // Test 4: redirect during a handshake, then a second redirect.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clock);
    chk("t4_pop_valid", {31'd0, if_valid}, 32'd1);
    next_cycle();
    redirect_pc = 32'h0000_0200;
    @(negedge clock);
    chk("t4_b2b_valid", {31'd0, if_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("t4_im_addr", im_addr, 32'h200);
    chk("t4_im_en", {31'd0, im_en}, 32'd1);
    next_cycle();
    @(negedge clock);
    chk("t4_r2_valid", {31'd0, if_valid}, 32'd0);
    next_cycle();
    @(negedge clock);
    chk("t4_first_pc_add", if_pc_add, 32'h204);
    chk("t4_first_inst", if_inst, 32'h1000_0080);
    next_cycle();
    @(negedge clock);
    chk("t4_second_pc_add", if_pc_add, 32'h208);
    repeat (2) next_cycle();

    // Test 6: one-cycle reset mid-stream; if_valid drops without a clock edge.
    chk("t6_pre_valid", {31'd0, if_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_async_im_en", {31'd0, im_en}, 32'd0);
    chk("t6_async_im_addr", im_addr, 32'h0);
    chk("t6_async_pc_add", if_pc_add, 32'h0);
    next_cycle();
    reset = 1'b0;
    check_startup("t6");
    repeat (4) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
